matrix_mac_engine: RTL and testbench

//  Parametrised successor to matrixTOP: computes P = A x X (A: ROWS x K coefficients, X: K x COLS streamed).

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_mac.sv | 68 ++++++
 rtl/matrix_mac_engine.sv | 204 ++++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Shared types and sizing helpers for the matrix multiply-accumulate engine.
//   state_e : engine FSM states
//   acc_w() : accumulator width that cannot overflow for a K-term dot product
//   idx_w() : index width for a count of n items (never below 1 bit)
// -----------------------------------------------------------------------------
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic int acc_w(input int data_w, input int k);
        return 2 * data_w + $clog2(k);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_mac.sv
// -----------------------------------------------------------------------------
// matrix_mac
//   One multiply-accumulate lane: acc <= (clr ? 0 : acc) + a*x, updated only
//   while en_i is high, so the result holds once accumulation stops.
//   Optional build macro: MATRIX_SIGNED_EN -- operands are two's complement and
//   the product is sign-extended; otherwise operands are unsigned and the
//   product is zero-extended.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high (clears the accumulator)
//   en_i   in   perform one multiply-accumulate this cycle
//   clr_i  in   first term of a new dot product (discard the old sum)
//   a_i    in   coefficient operand
//   x_i    in   data operand
//   acc_o  out  registered accumulator
// -----------------------------------------------------------------------------
module matrix_mac
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] x_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

`ifdef MATRIX_SIGNED_EN
    logic signed [2*DATA_W-1:0] prod_s;

    always_comb begin
        prod_s   = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i})
                 * $signed({{DATA_W{x_i[DATA_W-1]}}, x_i});
        // Size cast of a signed value sign-extends into the accumulator.
        prod_ext = ACC_W'(prod_s);
    end
`else
    logic [2*DATA_W-1:0] prod_u;

    always_comb begin
        prod_u   = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, x_i};
        prod_ext = ACC_W'(prod_u);
    end
`endif

    always_comb begin
        acc_d = clr_i ? prod_ext : (acc_q + prod_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mac_engine.sv
// -----------------------------------------------------------------------------
// matrix_mac_engine
//   Computes P = A x X. A (ROWS x K) is written through a register port while
//   idle; X (K x COLS) streams in column-major over valid/ready. Each result
//   element leaves on a valid/ready stream tagged with its row and column.
//   Optional build macro: MATRIX_SIGNED_EN -- A, X and results are two's
//   complement (default build: unsigned).
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   begin a job (honoured only when idle)
//   coef_we    in   coefficient write strobe (honoured only when idle)
//   coef_addr  in   coefficient address, row-major r*K+k
//   coef_data  in   coefficient value
//   x_valid    in   X element valid
//   x_ready    out  engine accepts an X element
//   x_data     in   X element
//   p_valid    out  result valid
//   p_ready    in   downstream accepts result
//   p_data     out  result P[p_row][p_col]
//   p_row      out  result row index
//   p_col      out  result column index
//   busy       out  job in progress
//   done       out  one-cycle pulse after the final result handshake
//
// State | Meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; coefficient writes accepted
// LOAD  | accepting K elements of the current X column into xbuf
// MAC   | K cycles of multiply-accumulate for the current row
// OUT   | result presented, held until p_ready
// -----------------------------------------------------------------------------
module matrix_mac_engine
    import matrix_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int K      = 4,
    parameter  int ROWS   = 4,
    parameter  int COLS   = 8,
    parameter  int ACC_W  = acc_w(DATA_W, K),
    localparam int AW     = idx_w(ROWS * K),
    localparam int KW     = idx_w(K),
    localparam int RW     = idx_w(ROWS),
    localparam int CW     = idx_w(COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x_data,
    output logic              p_valid,
    input  logic              p_ready,
    output logic [ACC_W-1:0]  p_data,
    output logic [RW-1:0]     p_row,
    output logic [CW-1:0]     p_col,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] coef_q [ROWS*K];
    logic [DATA_W-1:0] xbuf_q [K];

    logic              coef_wr;
    logic              x_wr;
    logic              mac_en;
    logic              mac_clr;
    logic [AW-1:0]     coef_idx;
    logic [ACC_W-1:0]  acc;

    assign coef_idx = AW'(int'(row_q) * K + int'(k_q));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        col_d   = col_q;
        done_d  = 1'b0;
        coef_wr = 1'b0;
        x_wr    = 1'b0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Coefficients are only writable here, so they stay frozen for a job.
                coef_wr = coef_we;
                if (start) begin
                    state_d = ST_LOAD;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            ST_LOAD: begin
                if (x_valid) begin
                    x_wr = 1'b1;
                    if (k_q == KW'(K - 1)) begin
                        k_d     = '0;
                        row_d   = '0;
                        state_d = ST_MAC;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end

            ST_MAC: begin
                mac_en  = 1'b1;
                mac_clr = (k_q == '0);
                if (k_q == KW'(K - 1)) begin
                    k_d     = '0;
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            ST_OUT: begin
                if (p_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d = '0;
                        if (col_q == CW'(COLS - 1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            col_d   = col_q + CW'(1);
                            k_d     = '0;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        row_d   = row_q + RW'(1);
                        state_d = ST_MAC;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < ROWS * K; i++) begin
                coef_q[i] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                xbuf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
            if (x_wr) begin
                xbuf_q[k_q] <= x_data;
            end
        end
    end

    // The accumulator is idle outside MAC, so it doubles as the held output register.
    matrix_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (mac_clr),
        .a_i   (coef_q[coef_idx]),
        .x_i   (xbuf_q[k_q]),
        .acc_o (acc)
    );

    assign x_ready = (state_q == ST_LOAD);
    assign p_valid = (state_q == ST_OUT);
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign p_data  = acc;
    assign p_row   = row_q;
    assign p_col   = col_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
module tb_matrix_mac_engine;

    localparam int DATA_W = 8;
    localparam int K      = 4;
    localparam int ROWS   = 4;
    localparam int COLS   = 8;
    localparam int ACC_W  = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              x_valid;
    logic              x_ready;
    logic [DATA_W-1:0] x_data;
    logic              p_valid;
    logic              p_ready;
    logic [ACC_W-1:0]  p_data;
    logic [1:0]        p_row;
    logic [2:0]        p_col;
    logic              busy;
    logic              done;

    int n_vec        = 0;
    int n_miscompare = 0;
    int done_cnt     = 0;

    int               a_m [ROWS*K];
    int               x_m [COLS][K];
    logic [ACC_W-1:0] got [COLS][ROWS];

    always #5 clk = ~clk;

    matrix_mac_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .p_data    (p_data),
        .p_row     (p_row),
        .p_col     (p_col),
        .busy      (busy),
        .done      (done)
    );

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] model(input int r, input int c);
        int s = 0;
        for (int k = 0; k < K; k++) s += a_m[r*K+k] * x_m[c][k];
        return ACC_W'(s);
    endfunction

    task automatic load_coefs();
        for (int i = 0; i < ROWS * K; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = DATA_W'(a_m[i]);
            @(negedge clk);
        end
        coef_we = 1'b0;
    endtask

    task automatic send_x(input logic [DATA_W-1:0] v);
        int t = 0;
        x_valid = 1'b1;
        x_data  = v;
        while (x_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (x_ready !== 1'b1) begin
            chk("x_ready_timeout", 32'(x_ready), 32'd1);
            x_valid = 1'b0;
            return;
        end
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic recv(input int r, input int c, input int stall);
        logic [ACC_W-1:0] e;
        int t = 0;
        e = model(r, c);
        p_ready = (stall == 0);
        while (p_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (p_valid !== 1'b1) begin
            chk($sformatf("p_valid_timeout r%0d c%0d", r, c), 32'(p_valid), 32'd1);
            p_ready = 1'b1;
            return;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid %0d", i), 32'(p_valid), 32'd1);
            chk($sformatf("stall_data %0d", i), 32'(p_data), 32'(e));
            chk($sformatf("stall_row %0d", i), 32'(p_row), 32'(r));
        end
        p_ready = 1'b1;
        chk($sformatf("p_data r%0d c%0d", r, c), 32'(p_data), 32'(e));
        chk($sformatf("p_row r%0d c%0d", r, c), 32'(p_row), 32'(r));
        chk($sformatf("p_col r%0d c%0d", r, c), 32'(p_col), 32'(c));
        got[c][r] = p_data;
        @(negedge clk);
    endtask

    task automatic run_job(input int stall_col, input int abort_col, input bit poke);
        int dc0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("x_ready_after_start", 32'(x_ready), 32'd1);
        for (int c = 0; c < COLS; c++) begin
            for (int k = 0; k < K; k++) begin
                if (c == abort_col && k == 2) begin
                    rst   = 1'b1;
                    start = 1'b1;
                    @(negedge clk);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_x_ready", 32'(x_ready), 32'd0);
                    chk("abort_p_valid", 32'(p_valid), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    rst   = 1'b0;
                    start = 1'b0;
                    @(negedge clk);
                    chk("start_in_rst_ignored", 32'(busy), 32'd0);
                    chk("abort_no_done", 32'(done_cnt), 32'(dc0));
                    return;
                end
                if (poke && c == 0 && k == 2) begin
                    coef_we   = 1'b1;
                    coef_addr = 4'd0;
                    coef_data = 8'd77;
                    start     = 1'b1;
                    @(negedge clk);
                    coef_we = 1'b0;
                    start   = 1'b0;
                end
                send_x(DATA_W'(x_m[c][k]));
            end
            for (int r = 0; r < ROWS; r++) begin
                recv(r, c, (c == stall_col && r == 1) ? 10 : 0);
            end
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("idle_after_job", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(dc0 + 1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        x_valid   = 1'b0;
        x_data    = '0;
        p_ready   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_x_ready", 32'(x_ready), 32'd0);
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'd0);
        chk("rst_p_row", 32'(p_row), 32'd0);
        chk("rst_p_col", 32'(p_col), 32'd0);

        // Identity A: P columns equal X columns.
        for (int i = 0; i < ROWS * K; i++) a_m[i] = ((i / K) == (i % K)) ? 1 : 0;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < K; k++) x_m[c][k] = c * K + k + 1;
        load_coefs();
        run_job(-1, -1, 1'b0);
        for (int r = 0; r < ROWS; r++) chk($sformatf("ident c0 r%0d", r), 32'(got[0][r]), 32'(r + 1));
        chk("ident c7 r3", 32'(got[7][3]), 32'd32);

`ifdef MATRIX_SIGNED_EN
        for (int i = 0; i < ROWS * K; i++) a_m[i] = -128;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < K; k++) x_m[c][k] = -128;
        load_coefs();
        run_job(-1, -1, 1'b0);
        chk("neg128 c0 r0", 32'(got[0][0]), 32'd65536);
        chk("neg128 c7 r3", 32'(got[7][3]), 32'd65536);

        for (int i = 0; i < ROWS * K; i++) a_m[i] = -1;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < K; k++) x_m[c][k] = 1;
        load_coefs();
        run_job(-1, -1, 1'b0);
        chk("minus1 c0 r0", 32'(got[0][0]), 32'h3FFFC);
        chk("minus1 c5 r2", 32'(got[5][2]), 32'h3FFFC);
`else
        for (int i = 0; i < ROWS * K; i++) a_m[i] = 255;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < K; k++) x_m[c][k] = 255;
        load_coefs();
        run_job(-1, -1, 1'b0);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                chk($sformatf("max c%0d r%0d", c, r), 32'(got[c][r]), 32'd260100);
`endif

        // Mixed values with a 10-cycle stall on column 2, row 1.
        for (int i = 0; i < ROWS * K; i++) a_m[i] = (i * 7 + 3) % 16;
        for (int c = 0; c < COLS; c++)
            for (int k = 0; k < K; k++) x_m[c][k] = (c * 5 + k * 3 + 1) % 20;
        load_coefs();
        run_job(2, -1, 1'b0);
        chk("hand c0 r0", 32'(got[0][0]), 32'd130);

        // start and coef_we pulsed mid-job must not disturb the job.
        run_job(-1, -1, 1'b1);
        chk("poke hand c0 r0", 32'(got[0][0]), 32'd130);

        // Reset during LOAD of column 3, then restart from column 0 with cleared coefficients.
        run_job(-1, 3, 1'b0);
        for (int i = 0; i < ROWS * K; i++) a_m[i] = 0;
        run_job(-1, -1, 1'b0);

        for (int i = 0; i < ROWS * K; i++) a_m[i] = (i * 7 + 3) % 16;
        load_coefs();
        run_job(-1, -1, 1'b0);
        chk("recover hand c0 r0", 32'(got[0][0]), 32'd130);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
